// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helpers for the FWFT read adapter and its skid buffer.
//   DATA_WIDTH_DEF : default read-data width
//   RD_LATENCY_DEF : default FIFO RAM read latency (1 or 2 cycles)
//   clog2()        : ceiling log2, used for pointer sizing
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int RD_LATENCY_DEF = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_fwft_rd_adapter_if.sv
// -----------------------------------------------------------------------------
// fifo_fwft_rd_adapter_if
// Bundles the FIFO read-side signals and the downstream valid/ready stream.
//   fifo_empty   : FIFO read-side empty flag
//   fifo_rd_data : FIFO RAM read data
//   fifo_rd_en   : read request to the FIFO read controller
//   m_valid      : m_data holds a valid word
//   m_data       : head-of-queue word
//   m_ready      : consumer accepts the word
//   buf_count    : words held in the skid buffer
// Modports:
//   master : the adapter (drives fifo_rd_en and the m_* stream)
//   slave  : the environment (FIFO + consumer)
// -----------------------------------------------------------------------------
interface fifo_fwft_rd_adapter_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_ready;
   logic [1:0]            buf_count;

   modport master (
      input  fifo_empty, fifo_rd_data, m_ready,
      output fifo_rd_en, m_valid, m_data, buf_count
   );

   modport slave (
      output fifo_empty, fifo_rd_data, m_ready,
      input  fifo_rd_en, m_valid, m_data, buf_count
   );

endinterface

// File: rtl/fwft_skid_buf.sv
// -----------------------------------------------------------------------------
// fwft_skid_buf
// Small circular buffer holding words returned by the FIFO RAM. The head word
// is presented combinationally (first-word-fall-through).
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_push      : write i_push_data at the tail
//   i_push_data : word to write
//   i_pop       : remove the head word
//   o_count     : number of words held (0..DEPTH)
//   o_head      : head word
// -----------------------------------------------------------------------------
module fwft_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = RD_LATENCY_DEF + 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [1:0]            o_count,
   output logic [DATA_WIDTH-1:0] o_head
);

   localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [1:0]            r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_do_pop  = i_pop && (r_count != 2'd0);
   assign w_do_push = i_push && ((r_count != 2'(DEPTH)) || w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_fwft_rd_adapter.sv
// -----------------------------------------------------------------------------
// fifo_fwft_rd_adapter
// Turns a FIFO with a registered RAM read (RD_LATENCY cycles) into a
// first-word-fall-through valid/ready stream with one word per cycle
// sustained throughput.
//   rd_clk   : read-domain clock, rising edge
//   rd_rst_n : asynchronous active-low reset
//   bus      : FIFO read side + m_* stream (see fifo_fwft_rd_adapter_if)
// -----------------------------------------------------------------------------
module fifo_fwft_rd_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic                   rd_clk,
   input  logic                   rd_rst_n,
   fifo_fwft_rd_adapter_if.master bus
);

   localparam int DEPTH = RD_LATENCY + 1;

   logic [RD_LATENCY-1:0] r_inflight;
   logic [1:0]            w_count;
   logic [1:0]            w_inflight_cnt;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_rd_en;
   logic [DATA_WIDTH-1:0] w_head;

   always_comb begin
      w_inflight_cnt = 2'd0;
      for (int i = 0; i < RD_LATENCY; i++)
         w_inflight_cnt = w_inflight_cnt + {1'b0, r_inflight[i]};
   end

   assign w_pop  = (w_count != 2'd0) && bus.m_ready;
   assign w_push = r_inflight[RD_LATENCY-1];

   // Issue a read only when every word already buffered or in flight, less the
   // one leaving this cycle, still leaves a free slot. Written as an addition
   // on the right so the compare never underflows. Gated by reset so nothing
   // is requested while the pipeline is being cleared.
   assign w_rd_en = rd_rst_n && !bus.fifo_empty &&
                    (({1'b0, w_count} + {1'b0, w_inflight_cnt}) <
                     (3'(DEPTH) + {2'b0, w_pop}));

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         r_inflight <= '0;
      end else begin
         r_inflight[0] <= w_rd_en;
         for (int i = 1; i < RD_LATENCY; i++) r_inflight[i] <= r_inflight[i-1];
      end
   end

   fwft_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_skid (
      .i_clk       (rd_clk),
      .i_rst_n     (rd_rst_n),
      .i_push      (w_push),
      .i_push_data (bus.fifo_rd_data),
      .i_pop       (w_pop),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign bus.fifo_rd_en = w_rd_en;
   assign bus.m_valid    = (w_count != 2'd0);
   assign bus.m_data     = w_head;
   assign bus.buf_count  = w_count;

endmodule
